vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Parametrised VGA timing generator; the next generation of the fixed 800x600 timing block.
- Produces hcount/vcount, sync and blank signals that map 1:1 onto the timing_if.out fields; downstream draw stages consume them via timing_if.in.
- Adds generic resolution and porch values, selectable sync polarity, a pixel-enable strobe (pixel rate below clk), line/frame start pulses and a frame counter.

Parameters:
- CNT_W, 11, width of hcount/vcount.
- H_ACTIVE, 800, visible pixels per line.
- H_FP, 40, horizontal front porch (pixels).
- H_SYNC, 128, horizontal sync width (pixels).
- H_BP, 88, horizontal back porch (pixels).
- V_ACTIVE, 600, visible lines per frame.
- V_FP, 1, vertical front porch (lines).
- V_SYNC, 4, vertical sync width (lines).
- V_BP, 23, vertical back porch (lines).
- H_SYNC_POL, 1, 1 = hsync active high, 0 = active low.
- V_SYNC_POL, 1, 1 = vsync active high, 0 = active low.
- FCNT_W, 8, width of frame_cnt.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active high.
- pix_en  in  1  pixel strobe; counters advance only on cycles where it is 1 (tie to 1 for pixel rate = clk).
- hcount  out  CNT_W  current pixel column, 0..H_TOTAL-1.
- vcount  out  CNT_W  current line, 0..V_TOTAL-1.
- hsync  out  1  horizontal sync, polarity per H_SYNC_POL.
- hblnk  out  1  horizontal blank, always active high.
- vsync  out  1  vertical sync, polarity per V_SYNC_POL.
- vblnk  out  1  vertical blank, always active high.
- line_start  out  1  one-clk pulse when hcount becomes 0.
- frame_start  out  1  one-clk pulse when (hcount,vcount) becomes (0,0).
- frame_cnt  out  FCNT_W  completed-frame counter.

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1056); V_TOTAL likewise (default 628).
- Elaboration check: H_TOTAL and V_TOTAL must be <= 2^CNT_W; every parameter must be >= 1; violation is a $fatal.
- All outputs are registered. Sync, blank and pulse outputs are decoded from the next counter values, so every output describes the same pixel as hcount/vcount in the same cycle.
- Reset (sync, rst=1 at a clk edge):
  - hcount=0, vcount=0, frame_cnt=0.
  - hblnk=0, vblnk=0.
  - hsync=!H_SYNC_POL, vsync=!V_SYNC_POL (inactive level).
  - line_start=0, frame_start=0.
  - rst overrides pix_en. Reset mid-frame returns to (0,0) on the next edge with no pulses.
  - First pix_en after reset moves to hcount=1. (0,0) is the first displayed pixel and is not flagged by frame_start.
- Advance on pix_en=1:
  - hcount = (hcount==H_TOTAL-1) ? 0 : hcount+1.
  - On hcount wrap: vcount = (vcount==V_TOTAL-1) ? 0 : vcount+1.
  - On vcount wrap: frame_cnt increments, wrapping modulo 2^FCNT_W.
- pix_en=0: counters and all levels hold; line_start and frame_start are 0. Pulses never exceed 1 clk, even if pix_en stays high.
- hblnk = 1 when hcount >= H_ACTIVE.
- hsync active when H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC.
- vblnk and vsync use the same rules on vcount with the V_* parameters. vsync and vblnk change only at hcount=0 boundaries.
- line_start = 1 in the cycle hcount goes H_TOTAL-1 -> 0.
- frame_start = line_start AND vcount goes V_TOTAL-1 -> 0. This is the same edge that increments frame_cnt.
- Simultaneous wrap of hcount, vcount and frame_cnt occurs in one edge. All three update together; there is no extra bubble cycle.
- Latency: pix_en at edge N -> new values visible after edge N.

Test Plan:
- Reset: rst=1 for 3 clk with pix_en=1 → hcount=0, vcount=0, hsync=vsync=1 (POL=0 build), blanks 0, no pulses; after release with pix_en=1 → hcount 1,2,3 on consecutive clk.
- Small geometry H 8/2/3/1, V 4/1/2/1 (H_TOTAL=14, V_TOTAL=8), pix_en=1:
  - hblnk=1 for hcount 8..13; hsync active for hcount 10..12.
  - line_start once per 14 clk; vblnk for vcount 4..7; vsync for vcount 5..6.
  - frame_start and frame_cnt+1 exactly every 112 clk.
- pix_en pattern 1-0-0-1 (pixel = clk/3 equivalent) → counters advance only on enabled edges; line_start width exactly 1 clk.
- Default 800x600: run 2 frames → frame_start period 1056*628 = 663168 enabled cycles; hsync asserted for hcount 840..967; vsync for vcount 601..604.
- rst asserted at hcount=500, vcount=300 → next clk (0,0), frame_cnt=0, no frame_start; normal progression resumes.
- FCNT_W=2, small geometry, 5 frames → frame_cnt 1,2,3,0,1.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Pixel-timing bundle from the VGA timing generator to downstream draw stages.
// master = generator side (drives every field), slave = consumer side.
interface vga_timing_gen_if #(
  parameter int CNT_W  = 11,
  parameter int FCNT_W = 8
);
  logic [CNT_W-1:0]  hcount;
  logic [CNT_W-1:0]  vcount;
  logic              hsync;
  logic              hblnk;
  logic              vsync;
  logic              vblnk;
  logic              line_start;
  logic              frame_start;
  logic [FCNT_W-1:0] frame_cnt;

  // No handshake: a new pixel description is presented every cycle and the
  // consumer samples all fields together; there is no valid/ready backpressure.
  modport master (
    output hcount, vcount, hsync, hblnk, vsync, vblnk,
           line_start, frame_start, frame_cnt
  );

  modport slave (
    input  hcount, vcount, hsync, hblnk, vsync, vblnk,
           line_start, frame_start, frame_cnt
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel/line counters with registered sync,
// blank, line/frame start pulses and a completed-frame counter.
module vga_timing_gen #(
  parameter int CNT_W      = 11,
  parameter int H_ACTIVE   = 800,
  parameter int H_FP       = 40,
  parameter int H_SYNC     = 128,
  parameter int H_BP       = 88,
  parameter int V_ACTIVE   = 600,
  parameter int V_FP       = 1,
  parameter int V_SYNC     = 4,
  parameter int V_BP       = 23,
  parameter int H_SYNC_POL = 1,
  parameter int V_SYNC_POL = 1,
  parameter int FCNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_en,
  vga_timing_gen_if.master tim
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam longint CNT_RANGE = longint'(1) << CNT_W;

  if (CNT_W < 1 || CNT_W > 31 || FCNT_W < 1) begin : g_bad_width
    $fatal(1, "vga_timing_gen: CNT_W must be 1..31 and FCNT_W >= 1");
  end
  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1) begin : g_bad_h
    $fatal(1, "vga_timing_gen: horizontal timing parameters must be >= 1");
  end
  if (V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_v
    $fatal(1, "vga_timing_gen: vertical timing parameters must be >= 1");
  end
  if (longint'(H_TOTAL) > CNT_RANGE || longint'(V_TOTAL) > CNT_RANGE) begin : g_bad_total
    $fatal(1, "vga_timing_gen: H_TOTAL/V_TOTAL exceed counter range");
  end
  if (H_SYNC_POL < 0 || H_SYNC_POL > 1 || V_SYNC_POL < 0 || V_SYNC_POL > 1) begin : g_bad_pol
    $fatal(1, "vga_timing_gen: sync polarity must be 0 or 1");
  end

  // All decode thresholds are strictly below the totals, so they fit CNT_W.
  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_BLNK_BEG = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_BLNK_BEG = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_ACT = (H_SYNC_POL != 0);
  localparam logic VS_ACT = (V_SYNC_POL != 0);

  logic [CNT_W-1:0]  hcount_q, hcount_d;
  logic [CNT_W-1:0]  vcount_q, vcount_d;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic              hsync_q, hsync_d;
  logic              hblnk_q, hblnk_d;
  logic              vsync_q, vsync_d;
  logic              vblnk_q, vblnk_d;
  logic              line_start_q, line_start_d;
  logic              frame_start_q, frame_start_d;
  logic              h_wrap;
  logic              v_wrap;

  always_comb begin
    h_wrap      = pix_en && (hcount_q == H_LAST);
    v_wrap      = h_wrap && (vcount_q == V_LAST);
    hcount_d    = hcount_q;
    vcount_d    = vcount_q;
    frame_cnt_d = frame_cnt_q;

    if (pix_en) begin
      hcount_d = h_wrap ? '0 : hcount_q + CNT_W'(1);
    end
    if (h_wrap) begin
      vcount_d = v_wrap ? '0 : vcount_q + CNT_W'(1);
    end
    if (v_wrap) begin
      frame_cnt_d = frame_cnt_q + FCNT_W'(1);
    end

    // Decode from the next counter values so every registered level lines up
    // with the hcount/vcount presented in the same cycle.
    hblnk_d = (hcount_d >= H_BLNK_BEG);
    vblnk_d = (vcount_d >= V_BLNK_BEG);
    hsync_d = ((hcount_d >= H_SYNC_BEG) && (hcount_d < H_SYNC_END)) ? HS_ACT : !HS_ACT;
    vsync_d = ((vcount_d >= V_SYNC_BEG) && (vcount_d < V_SYNC_END)) ? VS_ACT : !VS_ACT;

    line_start_d  = h_wrap;
    frame_start_d = v_wrap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      frame_cnt_q   <= '0;
      hblnk_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      hsync_q       <= !HS_ACT;
      vsync_q       <= !VS_ACT;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      frame_cnt_q   <= frame_cnt_d;
      hblnk_q       <= hblnk_d;
      vblnk_q       <= vblnk_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign tim.hcount      = hcount_q;
  assign tim.vcount      = vcount_q;
  assign tim.frame_cnt   = frame_cnt_q;
  assign tim.hsync       = hsync_q;
  assign tim.hblnk       = hblnk_q;
  assign tim.vsync       = vsync_q;
  assign tim.vblnk       = vblnk_q;
  assign tim.line_start  = line_start_q;
  assign tim.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a small active-low-sync geometry (14x8, 2-bit frame counter)
// and the default 800x600 build run side by side from shared clk/rst/pix_en.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_en = 1'b0;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.CNT_W(4),  .FCNT_W(2)) s_if ();
  vga_timing_gen_if #(.CNT_W(11), .FCNT_W(8)) d_if ();

  vga_timing_gen #(
    .CNT_W(4),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_SYNC_POL(0), .V_SYNC_POL(0),
    .FCNT_W(2)
  ) dut_s (
    .clk    (clk),
    .rst    (rst),
    .pix_en (pix_en),
    .tim    (s_if)
  );

  vga_timing_gen dut_d (
    .clk    (clk),
    .rst    (rst),
    .pix_en (pix_en),
    .tim    (d_if)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n        = 0;      // enabled edges since the last reset
  logic adv    = 1'b0;   // last edge advanced the counters

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s n=%0d observed=%0d expected=%0d", tag, n, obs, exp);
    end
  endtask

  // Expected values derived from the enabled-edge count alone.
  task automatic check_all();
    int h, v, f;
    h = n % 14;
    v = (n / 14) % 8;
    f = (n / 112) % 4;
    chk("s_hcount",      32'(s_if.hcount),      32'(h));
    chk("s_vcount",      32'(s_if.vcount),      32'(v));
    chk("s_frame_cnt",   32'(s_if.frame_cnt),   32'(f));
    chk("s_hblnk",       32'(s_if.hblnk),       32'(h >= 8));
    chk("s_hsync",       32'(s_if.hsync),       32'(!(h >= 10 && h <= 12)));
    chk("s_vblnk",       32'(s_if.vblnk),       32'(v >= 4));
    chk("s_vsync",       32'(s_if.vsync),       32'(!(v >= 5 && v <= 6)));
    chk("s_line_start",  32'(s_if.line_start),  32'(adv && h == 0));
    chk("s_frame_start", 32'(s_if.frame_start), 32'(adv && h == 0 && v == 0));

    h = n % 1056;
    v = (n / 1056) % 628;
    f = (n / 663168) % 256;
    chk("d_hcount",      32'(d_if.hcount),      32'(h));
    chk("d_vcount",      32'(d_if.vcount),      32'(v));
    chk("d_frame_cnt",   32'(d_if.frame_cnt),   32'(f));
    chk("d_hblnk",       32'(d_if.hblnk),       32'(h >= 800));
    chk("d_hsync",       32'(d_if.hsync),       32'(h >= 840 && h <= 967));
    chk("d_vblnk",       32'(d_if.vblnk),       32'(v >= 600));
    chk("d_vsync",       32'(d_if.vsync),       32'(v >= 601 && v <= 604));
    chk("d_line_start",  32'(d_if.line_start),  32'(adv && h == 0));
    chk("d_frame_start", 32'(d_if.frame_start), 32'(adv && h == 0 && v == 0));
  endtask

  // Apply pix_en for one edge (rst is whatever the caller left it at), then check.
  task automatic step(input logic en);
    pix_en = en;
    @(posedge clk);
    if (rst) begin
      n   = 0;
      adv = 1'b0;
    end else begin
      adv = en;
      if (en) n++;
    end
    #1;
    check_all();
  endtask

  initial begin
    // Reset held with pix_en high, then with pix_en low.
    rst = 1'b1;
    repeat (3) step(1'b1);
    step(1'b0);
    rst = 1'b0;

    // Free run: hcount 1,2,3,... and the first small-geometry line wrap.
    repeat (20) step(1'b1);

    // Pixel = clk/3: pulses must stay one clk wide while pix_en is low.
    repeat (20) begin
      step(1'b1);
      step(1'b0);
      step(1'b0);
    end

    // Enough enabled cycles for five-plus small frames (frame_cnt 1,2,3,0,1).
    repeat (600) step(1'b1);

    // Walk the default build to (500,1), crossing its hsync/hblnk window.
    for (int i = 0; i < 3000; i++) begin
      if ((n % 1056 == 500) && (n / 1056 >= 1)) break;
      step(1'b1);
    end
    chk("d_reach_mid_h", 32'(d_if.hcount), 32'd500);
    chk("d_reach_mid_v", 32'(d_if.vcount), 32'd1);

    // Mid-frame reset: back to (0,0), frame_cnt 0, no pulses.
    rst = 1'b1;
    step(1'b1);
    rst = 1'b0;
    repeat (30) step(1'b1);

    // Random enable pattern.
    repeat (300) step(1'($urandom_range(0, 1)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
